// File: rtl/memory_responder_if.sv
// Initiator-to-responder bus: word address, byte strobes, read/write requests and read data.
// The initiator drives the request side; the responder returns data_out with zero wait states.
interface memory_responder_if;
  logic [31:2] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [3:0]  data_strobes;
  logic        read;
  logic        write;
  logic        bus_error;

  modport master (
    output address, data_in, data_strobes, read, write, bus_error,
    input  data_out
  );

  modport slave (
    input  address, data_in, data_strobes, read, write, bus_error,
    output data_out
  );
endinterface

// File: rtl/memory_responder.sv
// Zero-wait-state memory responder: byte-writable RAM plus COUNTER, LEDS and STATUS registers.
// Reads are combinational from the address; all state changes happen on the rising clock edge.
module memory_responder #(
  parameter int RAM_WORDS = 1024,
  parameter     INIT_FILE = ""
) (
  input  logic              clock,
  input  logic              reset,
  memory_responder_if.slave bus,
  input  logic              halted,
  output logic [7:0]        leds,
  output logic              fault
);
  localparam int          ADDR_BITS    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [31:2] RAM_LIMIT    = 30'(RAM_WORDS);
  localparam logic [31:2] COUNTER_ADDR = 30'h2000_0000;
  localparam logic [31:2] LEDS_ADDR    = 30'h2000_0001;
  localparam logic [31:2] STATUS_ADDR  = 30'h2000_0002;

  logic [31:0] mem [RAM_WORDS];

  logic [31:0] counter_reg;
  logic [7:0]  leds_reg;
  logic [1:0]  status_reg;   // bit0 UNMAPPED, bit1 ILLEGAL
  logic [1:0]  status_next;

  logic ram_hit, counter_hit, leds_hit, status_hit, unmapped;
  logic access, illegal, wr_en, ram_we;
  logic [ADDR_BITS-1:0] ram_index;
  logic [3:0] lane_we;
  logic [1:0] status_set, status_clear;

  assign ram_hit     = bus.address < RAM_LIMIT;
  assign counter_hit = bus.address == COUNTER_ADDR;
  assign leds_hit    = bus.address == LEDS_ADDR;
  assign status_hit  = bus.address == STATUS_ADDR;
  assign unmapped    = ~(ram_hit | counter_hit | leds_hit | status_hit);
  assign ram_index   = bus.address[ADDR_BITS+1:2];

  // bus_error suppresses everything, including status reporting.
  assign access  = (bus.read | bus.write) & ~bus.bus_error;
  assign illegal = bus.read & bus.write & ~bus.bus_error;
  assign wr_en   = bus.write & ~bus.read & ~bus.bus_error & ~reset;
  assign ram_we  = wr_en & ram_hit;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_we[gi] = ram_we & bus.data_strobes[gi];
    end
  endgenerate

  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) begin
        mem[ram_index][8*i +: 8] <= bus.data_in[8*i +: 8];
      end
    end
  end

  // A set and a write-1-to-clear on the same bit resolve in favour of the set.
  always_comb begin
    status_set   = {illegal, access & unmapped};
    status_clear = 2'b00;
    if (wr_en && status_hit && bus.data_strobes[0]) begin
      status_clear = bus.data_in[1:0];
    end
    status_next = status_set | (status_reg & ~status_clear);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      counter_reg <= 32'h0;
      leds_reg    <= 8'h00;
      status_reg  <= 2'b00;
    end else begin
      if (!halted) begin
        counter_reg <= counter_reg + 32'd1;
      end
      if (wr_en && leds_hit && bus.data_strobes[0]) begin
        leds_reg <= bus.data_in[7:0];
      end
      status_reg <= status_next;
    end
  end

  // While reset is held the registers already read back their reset values.
  always_comb begin
    bus.data_out = 32'h0;
    if (bus.read && !bus.write && !bus.bus_error) begin
      if (ram_hit) begin
        bus.data_out = mem[ram_index];
      end else if (!reset) begin
        if (counter_hit) begin
          bus.data_out = counter_reg;
        end else if (leds_hit) begin
          bus.data_out = {24'h0, leds_reg};
        end else if (status_hit) begin
          bus.data_out = {30'h0, status_reg};
        end
      end
    end
  end

  assign leds  = leds_reg;
  assign fault = |status_reg;
endmodule

// File: tb/tb_memory_responder.sv
// Randomized + directed bench for memory_responder with a queue-based scoreboard.
module tb_memory_responder;
  localparam int WORDS = 64;
  localparam int R_RAM = 0, R_CNT = 1, R_LED = 2, R_STS = 3, R_NONE = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       halted;
  logic [7:0] leds;
  logic       fault;

  memory_responder_if bus();

  memory_responder #(.RAM_WORDS(WORDS), .INIT_FILE("")) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .halted(halted),
    .leds  (leds),
    .fault (fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          id;
    logic [31:0] exp_data;
    bit          chk_regs;
    logic        exp_fault;
    logic [7:0]  exp_leds;
  } item_t;

  item_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state: what the design should hold after the last edge.
  logic [31:0] m_ram [WORDS];
  logic [31:0] m_counter;
  logic [7:0]  m_leds;
  logic        m_unm, m_ill;
  bit          m_known = 0;

  function automatic int region(input logic [31:0] a);
    if (a < 32'(4*WORDS)) return R_RAM;
    if (a == 32'h8000_0000) return R_CNT;
    if (a == 32'h8000_0004) return R_LED;
    if (a == 32'h8000_0008) return R_STS;
    return R_NONE;
  endfunction

  // One bus cycle: drive at the falling edge, queue the expectation, advance the model.
  task automatic cycle(input bit rst, input bit rd, input bit wr, input bit berr, input bit halt,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input bit use_const = 0, input logic [31:0] cval = 32'h0);
    item_t it;
    int r;
    int idx;
    bit set_u, set_i;
    @(negedge clock);
    reset = rst; halted = halt;
    bus.address = a[31:2]; bus.data_in = d; bus.data_strobes = s;
    bus.read = rd; bus.write = wr; bus.bus_error = berr;
    r = region(a);
    idx = int'(a >> 2);
    it.id = cyc;
    it.chk_regs = m_known;
    it.exp_fault = m_unm | m_ill;
    it.exp_leds = m_leds;
    it.exp_data = 32'h0;
    if (rd && !wr && !berr) begin
      case (r)
        R_RAM: it.exp_data = m_ram[idx];
        R_CNT: it.exp_data = rst ? 32'h0 : m_counter;
        R_LED: it.exp_data = rst ? 32'h0 : {24'h0, m_leds};
        R_STS: it.exp_data = rst ? 32'h0 : {30'h0, m_ill, m_unm};
        default: it.exp_data = 32'h0;
      endcase
    end
    if (use_const) it.exp_data = cval;
    sb.push_back(it);
    cyc++;
    if (rst) begin
      m_counter = 32'h0; m_leds = 8'h00; m_unm = 1'b0; m_ill = 1'b0; m_known = 1;
    end else begin
      set_u = !berr && (rd || wr) && (r == R_NONE);
      set_i = !berr && rd && wr;
      if (!berr && wr && !rd) begin
        case (r)
          R_RAM: for (int i = 0; i < 4; i++) if (s[i]) m_ram[idx][8*i +: 8] = d[8*i +: 8];
          R_LED: if (s[0]) m_leds = d[7:0];
          R_STS: if (s[0]) begin
                   if (d[0]) m_unm = 1'b0;
                   if (d[1]) m_ill = 1'b0;
                 end
          default: ;
        endcase
      end
      if (set_u) m_unm = 1'b1;
      if (set_i) m_ill = 1'b1;
      if (!halt) m_counter = m_counter + 32'd1;
    end
  endtask

  // Monitor: samples 2 time units after the falling edge, well clear of the rising edge.
  initial begin
    item_t it;
    forever begin
      @(negedge clock);
      #2;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        checks++;
        if (bus.data_out !== it.exp_data) begin
          errors++;
          $display("FAIL data_out cycle %0d: got %h expected %h", it.id, bus.data_out, it.exp_data);
        end
        if (it.chk_regs) begin
          checks++;
          if (fault !== it.exp_fault) begin
            errors++;
            $display("FAIL fault cycle %0d: got %b expected %b", it.id, fault, it.exp_fault);
          end
          checks++;
          if (leds !== it.exp_leds) begin
            errors++;
            $display("FAIL leds cycle %0d: got %h expected %h", it.id, leds, it.exp_leds);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    int k;
    int guard;
    bit rd, wr;
    reset = 1'b1; halted = 1'b0;
    bus.address = '0; bus.data_in = '0; bus.data_strobes = '0;
    bus.read = 1'b0; bus.write = 1'b0; bus.bus_error = 1'b0;

    cycle(1, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    cycle(1, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    for (int w = 0; w < WORDS; w++) cycle(0, 0, 1, 0, 1, 32'(w*4), $urandom, 4'hF);

    // Byte-lane writes merge into the existing word.
    cycle(0, 0, 1, 0, 1, 32'h10, 32'h1122_3344, 4'b1111);
    cycle(0, 0, 1, 0, 1, 32'h10, 32'hAABB_CCDD, 4'b0101);
    cycle(0, 1, 0, 0, 1, 32'h10, 32'h0, 4'hF, 1, 32'h11BB_33DD);

    // Counter: 10 running clocks after reset, then frozen while halted.
    cycle(1, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    repeat (10) cycle(0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    repeat (5) cycle(0, 1, 0, 0, 1, 32'h8000_0000, 32'h0, 4'hF, 1, 32'd10);
    cycle(0, 0, 0, 0, 1, 32'h0, 32'h0, 4'h0);
    force dut.counter_reg = 32'hFFFF_FFFF;
    release dut.counter_reg;
    m_counter = 32'hFFFF_FFFF;
    cycle(0, 1, 0, 0, 0, 32'h8000_0000, 32'h0, 4'hF, 1, 32'hFFFF_FFFF);
    cycle(0, 1, 0, 0, 1, 32'h8000_0000, 32'h0, 4'hF, 1, 32'h0);

    // LEDs: only lane 0 matters.
    cycle(0, 0, 1, 0, 1, 32'h8000_0004, 32'h0000_01A5, 4'b1111);
    cycle(0, 1, 0, 0, 1, 32'h8000_0004, 32'h0, 4'hF, 1, 32'h0000_00A5);
    cycle(0, 0, 1, 0, 1, 32'h8000_0004, 32'h0000_015A, 4'b1110);
    cycle(0, 1, 0, 0, 1, 32'h8000_0004, 32'h0, 4'hF, 1, 32'h0000_00A5);

    // Unmapped access sets status; write-1-to-clear removes it.
    cycle(0, 1, 0, 0, 1, 32'h4000_0000, 32'h0, 4'hF, 1, 32'h0);
    cycle(0, 1, 0, 0, 1, 32'h8000_0008, 32'h0, 4'hF, 1, 32'h1);
    cycle(0, 0, 1, 0, 1, 32'h8000_0008, 32'h1, 4'hF);
    cycle(0, 1, 0, 0, 1, 32'h8000_0008, 32'h0, 4'hF, 1, 32'h0);
    cycle(0, 1, 0, 0, 1, 32'(4*WORDS), 32'h0, 4'hF, 1, 32'h0);
    cycle(0, 1, 0, 0, 1, 32'(4*WORDS-4), 32'h0, 4'hF);
    cycle(0, 0, 1, 0, 1, 32'h8000_0008, 32'h3, 4'h1);

    // Illegal read+write and suppressed bus_error cycles.
    cycle(0, 1, 1, 0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1, 32'h0);
    cycle(0, 1, 0, 0, 1, 32'h10, 32'h0, 4'hF, 1, 32'h11BB_33DD);
    cycle(0, 1, 0, 0, 1, 32'h8000_0008, 32'h0, 4'hF, 1, 32'h2);
    cycle(0, 0, 1, 0, 1, 32'h8000_0008, 32'h2, 4'h1);
    cycle(0, 0, 1, 1, 1, 32'h10, 32'h0, 4'hF);
    cycle(0, 1, 0, 1, 1, 32'h4000_0000, 32'h0, 4'hF, 1, 32'h0);
    cycle(0, 0, 1, 1, 1, 32'h8000_0004, 32'h0, 4'hF);
    cycle(0, 1, 0, 0, 1, 32'h10, 32'h0, 4'hF, 1, 32'h11BB_33DD);
    cycle(0, 1, 0, 0, 1, 32'h8000_0008, 32'h0, 4'hF, 1, 32'h0);

    // Reset during a RAM write with fault and LEDs set.
    cycle(0, 1, 0, 0, 1, 32'h4000_0000, 32'h0, 4'hF);
    cycle(0, 0, 1, 0, 1, 32'h8000_0004, 32'hFF, 4'hF);
    cycle(1, 0, 1, 0, 1, 32'h10, 32'h5555_5555, 4'hF);
    cycle(0, 1, 0, 0, 1, 32'h10, 32'h0, 4'hF, 1, 32'h11BB_33DD);
    cycle(0, 1, 0, 0, 1, 32'h8000_0000, 32'h0, 4'hF, 1, 32'h0);
    cycle(0, 1, 0, 0, 1, 32'h8000_0008, 32'h0, 4'hF, 1, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 32'($urandom_range(0, WORDS-1) * 4);
        4: a = 32'(4*WORDS - 4);
        5: a = 32'h8000_0000;
        6: a = 32'h8000_0004;
        7: a = 32'h8000_0008;
        8: a = ($urandom_range(0, 1) == 0) ? 32'(4*WORDS) : 32'h8000_000C;
        default: a = {$urandom, 2'b00} & 32'hFFFF_FFFC;
      endcase
      k = $urandom_range(0, 19);
      rd = (k < 8) || (k >= 16 && k < 18);
      wr = (k >= 8 && k < 18);
      cycle($urandom_range(0, 99) == 0, rd, wr, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) == 0, a, $urandom, 4'($urandom_range(0, 15)));
    end
    cycle(0, 0, 0, 0, 1, 32'h0, 32'h0, 4'h0);

    guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      @(negedge clock);
      #3;
      guard++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d items left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
